data_mem_responder: RTL and testbench

Memory-stage responder that serves the `mem_read`/`mem_write` requests issued by the decode control path. It owns the data-memory word array, models a fixed multi-cycle access latency, and drives `ready` so the pipeline freezes until each access completes. It sits between the MEM pipeline stage and the data storage. Read data is registered and held until the next completed read.

---
 rtl/data_mem_responder.sv | 90 +++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: owns the word array and holds the
// pipeline frozen (ready=0) for a fixed number of BUSY cycles per access.
module data_mem_responder #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(1024),
  parameter int unsigned       WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wd_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]  off;
  logic [IDX_W-1:0]   req_idx;
  logic               req;
  logic               access_now;
  logic               mem_we;
  logic               unused_off;

  // Wrapping subtract then drop byte offset; upper bits alias by truncation.
  assign off        = address - BASE_ADDR;
  assign req_idx    = off[IDX_W+1:2];
  assign unused_off = ^{off[ADDR_W-1:IDX_W+2], off[1:0]};

  assign req        = mem_read | mem_write;
  assign access_now = (state_q == BUSY) && (cnt_q == CNT_W'(1));
  // Gate with rst_n so an in-flight store is dropped when reset hits.
  assign mem_we     = rst_n && access_now && wr_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= BUSY;
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            wr_q    <= mem_write & ~mem_read;  // read wins when both asserted
            idx_q   <= req_idx;
            wd_q    <= wdata;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (access_now) begin
            state_q <= DONE;
            if (!wr_q) rdata_q <= mem[idx_q];
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == IDLE) ? ~req : (state_q == DONE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// accesses against a word-array reference model.
module tb_data_mem_responder;

  localparam int          W    = 4;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [31:0] mem_m [64];
  logic [31:0] rdata_m = '0;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'((o >> 2) % 32'd64);
  endfunction

  // Drives one request starting in the current (IDLE) cycle, holds it through
  // the freeze, checks freeze length and DONE-cycle rdata, then drops it.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input string nm,
                        output logic [31:0] got, output int done_cyc);
    int frz;
    mem_read = rd; mem_write = wr; address = a; wdata = d;
    if (rd) rdata_m = mem_m[widx(a)];
    else if (wr) mem_m[widx(a)] = d;
    frz = 0;
    @(negedge clk);
    while (ready !== 1'b1 && frz < 40) begin
      frz++;
      @(negedge clk);
    end
    done_cyc = cyc;
    got = rdata;
    vectors++;
    if (frz != W + 1) begin
      errors++;
      $display("FAIL %s freeze: got %0d cycles, expected %0d", nm, frz, W + 1);
    end
    vectors++;
    if (rdata !== rdata_m) begin
      errors++;
      $display("FAIL %s rdata: got %h, expected %h", nm, rdata, rdata_m);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b rdata=%h, expected ready=1 rdata=0", ready, rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle_ready: cycle %0d ready=%b, expected 1", i, ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [31:0] g; int dc;
    for (int i = 0; i < 64; i++)
      access(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, "fill", g, dc);
  endtask

  task automatic test_write_read();
    logic [31:0] g; int dc;
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "wr_deadbeef", g, dc);
    access(1'b1, 1'b0, 32'd1024, 32'h0, "rd_deadbeef", g, dc);
    vectors++;
    if (g !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read: got %h, expected deadbeef", g);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g; int dc1, dc2, t0;
    t0 = cyc;
    access(1'b0, 1'b1, 32'd1028, 32'h1, "b2b_wr", g, dc1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, "b2b_rd", g, dc2);
    vectors++;
    if (dc2 - t0 + 1 != 12 || g !== 32'h1) begin
      errors++;
      $display("FAIL back_to_back: span %0d cycles rdata %h, expected 12 cycles rdata 1",
               dc2 - t0 + 1, g);
    end
  endtask

  task automatic test_alias();
    logic [31:0] g; int dc;
    access(1'b0, 1'b1, 32'd1280, 32'h11, "alias_wr", g, dc);
    access(1'b0, 1'b1, 32'd1032, 32'h22, "alias_other", g, dc);
    access(1'b1, 1'b0, 32'd1024, 32'h0, "alias_rd1024", g, dc);
    vectors++;
    if (g !== 32'h11) begin
      errors++;
      $display("FAIL alias_1024: got %h, expected 11", g);
    end
    access(1'b1, 1'b0, 32'd1028, 32'h0, "alias_clear", g, dc);
    access(1'b1, 1'b0, 32'd1027, 32'h0, "alias_rd1027", g, dc);
    vectors++;
    if (g !== 32'h11) begin
      errors++;
      $display("FAIL alias_1027: got %h, expected 11", g);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] g; int dc;
    access(1'b0, 1'b1, 32'd1032, 32'h5, "rst_pre_wr", g, dc);
    access(1'b1, 1'b0, 32'd1032, 32'h0, "rst_pre_rd", g, dc);
    mem_write = 1'b1; address = 32'd1032; wdata = 32'hAAAA;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0; mem_write = 1'b0;
    #1;
    rdata_m = '0;
    vectors++;
    if (rdata !== 32'h0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: rdata=%h ready=%b, expected rdata=0 ready=1", rdata, ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1032, 32'h0, "rst_post_rd", g, dc);
    vectors++;
    if (g !== 32'h5) begin
      errors++;
      $display("FAIL reset_mid_keep: got %h, expected 5", g);
    end
  endtask

  task automatic test_both();
    logic [31:0] g; int dc;
    access(1'b0, 1'b1, 32'd1036, 32'h7, "both_pre", g, dc);
    access(1'b1, 1'b1, 32'd1036, 32'hFF, "both_rw", g, dc);
    vectors++;
    if (g !== 32'h7) begin
      errors++;
      $display("FAIL both_rdata: got %h, expected 7", g);
    end
    access(1'b1, 1'b0, 32'd1040, 32'h0, "both_other", g, dc);
    access(1'b1, 1'b0, 32'd1036, 32'h0, "both_after", g, dc);
    vectors++;
    if (g !== 32'h7) begin
      errors++;
      $display("FAIL both_unchanged: got %h, expected 7", g);
    end
  endtask

  task automatic test_random();
    logic [31:0] g, a; int dc, op, gap;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 3) == 0) ? $urandom
                                       : BASE + 32'($urandom_range(0, 255));
      access(op != 1, op != 0, a, $urandom, "random", g, dc);
      gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1 || rdata !== rdata_m) begin
          errors++;
          $display("FAIL random_idle: ready=%b rdata=%h, expected ready=1 rdata=%h",
                   ready, rdata, rdata_m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_back_to_back();
    test_alias();
    test_reset_mid_write();
    test_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
